// File: rtl/banco_registradores_entrada_pkg.sv
// Shared types and default sizes for the register file with switch-input handshake.
package banco_pkg;

  localparam int LARGURA_PADRAO  = 32;
  localparam int NUM_REGS_PADRAO = 32;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    AGUARDA = 2'd1,
    CONCLUI = 2'd2
  } estado_entrada_t;

endpackage

// File: rtl/banco_registradores_entrada_if.sv
// Bus between the UC/datapath (master) and the register file (slave).
interface banco_registradores_entrada_if
  import banco_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int NUM_REGS = NUM_REGS_PADRAO
);
  localparam int LARG_END = $clog2(NUM_REGS);

  logic [LARG_END-1:0] enderecoLeitura1;
  logic [LARG_END-1:0] enderecoLeitura2;
  logic [LARGURA-1:0]  dadoLeitura1;
  logic [LARGURA-1:0]  dadoLeitura2;
  logic                escritaHabilita;
  logic [LARG_END-1:0] enderecoEscrita;
  logic [LARGURA-1:0]  dadoEscrita;
  logic                pedidoEntrada;
  logic [LARG_END-1:0] enderecoEntrada;
  logic                confirmaEntrada;
  logic [LARGURA-1:0]  dadoSwitch;
  logic                ocupado;
  logic                entradaConcluida;

  modport master (
    output enderecoLeitura1, enderecoLeitura2, escritaHabilita, enderecoEscrita,
           dadoEscrita, pedidoEntrada, enderecoEntrada, confirmaEntrada, dadoSwitch,
    input  dadoLeitura1, dadoLeitura2, ocupado, entradaConcluida
  );

  modport slave (
    input  enderecoLeitura1, enderecoLeitura2, escritaHabilita, enderecoEscrita,
           dadoEscrita, pedidoEntrada, enderecoEntrada, confirmaEntrada, dadoSwitch,
    output dadoLeitura1, dadoLeitura2, ocupado, entradaConcluida
  );

endinterface

// File: rtl/banco_registradores_entrada_controle.sv
// Input handshake FSM: latches the destination on request, emits one write on confirm.
module controle_entrada
  import banco_pkg::*;
#(
  parameter int LARG_END = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pedido_i,
  input  logic [LARG_END-1:0] endereco_i,
  input  logic                confirma_i,
  output logic                ocupado_o,
  output logic                concluida_o,
  output logic                escrita_o,
  output logic [LARG_END-1:0] endereco_o
);

  estado_entrada_t     estado_q, estado_d;
  logic [LARG_END-1:0] end_q, end_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_q <= OCIOSO;
      end_q    <= '0;
    end else begin
      estado_q <= estado_d;
      end_q    <= end_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    end_d     = end_q;
    escrita_o = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (pedido_i) begin
          end_d    = endereco_i;
          estado_d = AGUARDA;
        end
      end
      AGUARDA: begin
        if (confirma_i) begin
          escrita_o = (end_q != '0);
          estado_d  = CONCLUI;
        end
      end
      CONCLUI: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  assign ocupado_o   = (estado_q != OCIOSO);
  assign concluida_o = (estado_q == CONCLUI);
  assign endereco_o  = end_q;

endmodule

// File: rtl/banco_registradores_entrada.sv
// Register file, 2 async reads / 1 sync write, r0 hardwired to zero, switch-input handshake.
// Optional same-cycle UC write forwarding to reads under BANCO_BYPASS_EN.
module banco_registradores_entrada
  import banco_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int NUM_REGS = NUM_REGS_PADRAO
) (
  input logic                          clock,
  input logic                          reset,
  banco_registradores_entrada_if.slave bus
);

  localparam int LARG_END = $clog2(NUM_REGS);

  logic [LARGURA-1:0]  banco_q [NUM_REGS];
  logic                ocupado;
  logic                esc_entrada;
  logic [LARG_END-1:0] end_entrada;
  logic                esc_uc;
  logic                we_d;
  logic [LARG_END-1:0] waddr_d;
  logic [LARGURA-1:0]  wdata_d;

  controle_entrada #(.LARG_END(LARG_END)) u_controle (
    .clk_i       (clock),
    .rst_i       (reset),
    .pedido_i    (bus.pedidoEntrada),
    .endereco_i  (bus.enderecoEntrada),
    .confirma_i  (bus.confirmaEntrada),
    .ocupado_o   (ocupado),
    .concluida_o (bus.entradaConcluida),
    .escrita_o   (esc_entrada),
    .endereco_o  (end_entrada)
  );

  assign bus.ocupado = ocupado;
  assign esc_uc      = bus.escritaHabilita && !ocupado && (bus.enderecoEscrita != '0);

  // The two sources are mutually exclusive: the input write only occurs while ocupado=1.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    if (esc_entrada) begin
      we_d    = 1'b1;
      waddr_d = end_entrada;
      wdata_d = bus.dadoSwitch;
    end else if (esc_uc) begin
      we_d    = 1'b1;
      waddr_d = bus.enderecoEscrita;
      wdata_d = bus.dadoEscrita;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) banco_q[i] <= '0;
    end else if (we_d) begin
      banco_q[waddr_d] <= wdata_d;
    end
  end

  always_comb begin
    bus.dadoLeitura1 = (bus.enderecoLeitura1 == '0) ? '0 : banco_q[bus.enderecoLeitura1];
    bus.dadoLeitura2 = (bus.enderecoLeitura2 == '0) ? '0 : banco_q[bus.enderecoLeitura2];
`ifdef BANCO_BYPASS_EN
    if (esc_uc && (bus.enderecoLeitura1 == bus.enderecoEscrita)) bus.dadoLeitura1 = bus.dadoEscrita;
    if (esc_uc && (bus.enderecoLeitura2 == bus.enderecoEscrita)) bus.dadoLeitura2 = bus.dadoEscrita;
`endif
  end

endmodule

// File: tb/tb_banco_registradores_entrada.sv
// Bench for banco_registradores_entrada: directed test-plan sequences plus random traffic vs a reference model.
module tb_banco_registradores_entrada;
  localparam int LARGURA  = 32;
  localparam int NUM_REGS = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  banco_registradores_entrada_if #(.LARGURA(LARGURA), .NUM_REGS(NUM_REGS)) bus ();

  banco_registradores_entrada #(.LARGURA(LARGURA), .NUM_REGS(NUM_REGS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_ocup, n_conc;

  logic [31:0] m_mem [NUM_REGS];
  bit          m_wait, m_done;
  logic [4:0]  m_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef BANCO_BYPASS_EN
    if (bus.escritaHabilita && !(m_wait || m_done) && bus.enderecoEscrita != 0 &&
        bus.enderecoEscrita == a) return bus.dadoEscrita;
`endif
    return m_mem[a];
  endfunction

  task automatic model_step();
    bit busy;
    busy = m_wait || m_done;
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      m_wait = 0; m_done = 0; m_addr = 0;
      return;
    end
    if (!busy && bus.escritaHabilita && bus.enderecoEscrita != 0)
      m_mem[bus.enderecoEscrita] = bus.dadoEscrita;
    if (m_done) m_done = 0;
    else if (m_wait) begin
      if (bus.confirmaEntrada) begin
        if (m_addr != 0) m_mem[m_addr] = bus.dadoSwitch;
        m_wait = 0; m_done = 1;
      end
    end else if (bus.pedidoEntrada) begin
      m_wait = 1; m_addr = bus.enderecoEntrada;
    end
  endtask

  // One clock: check all outputs mid-cycle, advance the model, return just after the edge.
  task automatic cycle();
    @(negedge clock);
    check("rd1", bus.dadoLeitura1, exp_read(bus.enderecoLeitura1));
    check("rd2", bus.dadoLeitura2, exp_read(bus.enderecoLeitura2));
    check("ocupado", {31'b0, bus.ocupado}, {31'b0, m_wait || m_done});
    check("concluida", {31'b0, bus.entradaConcluida}, {31'b0, m_done});
    if (bus.ocupado) n_ocup++;
    if (bus.entradaConcluida) n_conc++;
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0;
    bus.escritaHabilita = 0; bus.enderecoEscrita = 0; bus.dadoEscrita = 0;
    bus.pedidoEntrada = 0; bus.enderecoEntrada = 0;
    bus.confirmaEntrada = 0; bus.dadoSwitch = 0;
  endtask

  task automatic uc_write(input logic [4:0] a, input logic [31:0] d);
    idle();
    bus.escritaHabilita = 1; bus.enderecoEscrita = a; bus.dadoEscrita = d;
    cycle();
    idle();
  endtask

  task automatic expect_rd(input string tag, input logic [4:0] a, input logic [31:0] d);
    bus.enderecoLeitura1 = a;
    #1;
    check(tag, bus.dadoLeitura1, d);
  endtask

  initial begin
    idle();
    bus.enderecoLeitura1 = 0; bus.enderecoLeitura2 = 0;
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    foreach (m_mem[i]) m_mem[i] = 32'h0;
    m_wait = 0; m_done = 0; m_addr = 0;
    cycle();

    // Reset clears registers
    uc_write(5, 32'hDEADBEEF);
    expect_rd("r5_written", 5, 32'hDEADBEEF);
    reset = 1; cycle(); idle(); cycle();
    expect_rd("r5_after_reset", 5, 32'h0);
    check("ocupado_after_reset", {31'b0, bus.ocupado}, 32'h0);

    // Write/read, r0 discard
    uc_write(3, 32'h12345678);
    expect_rd("r3", 3, 32'h12345678);
    uc_write(0, 32'hFFFFFFFF);
    expect_rd("r0", 0, 32'h0);

    // Bypass behaviour
    uc_write(7, 32'h00000011);
    bus.escritaHabilita = 1; bus.enderecoEscrita = 7; bus.dadoEscrita = 32'hA5A5A5A5;
`ifdef BANCO_BYPASS_EN
    expect_rd("r7_same_cycle", 7, 32'hA5A5A5A5);
`else
    expect_rd("r7_same_cycle", 7, 32'h00000011);
`endif
    cycle(); idle();
    expect_rd("r7_next_cycle", 7, 32'hA5A5A5A5);

    // Input handshake: request r9, 4 waiting cycles, confirm 0x2A
    n_ocup = 0; n_conc = 0;
    bus.enderecoLeitura2 = 9;
    bus.pedidoEntrada = 1; bus.enderecoEntrada = 9; cycle(); idle();
    repeat (4) cycle();
    bus.confirmaEntrada = 1; bus.dadoSwitch = 32'h2A; cycle(); idle();
    repeat (2) cycle();
    check("ocupado_cycles", n_ocup, 6);
    check("concluida_pulses", n_conc, 1);
    expect_rd("r9", 9, 32'h2A);

    // Blocking: UC write and second request ignored during AGUARDA
    uc_write(4, 32'h00000033);
    bus.pedidoEntrada = 1; bus.enderecoEntrada = 9; cycle(); idle();
    bus.escritaHabilita = 1; bus.enderecoEscrita = 4; bus.dadoEscrita = 32'h55; cycle(); idle();
    bus.pedidoEntrada = 1; bus.enderecoEntrada = 12; cycle(); idle();
    bus.confirmaEntrada = 1; bus.dadoSwitch = 32'h77; cycle(); idle();
    cycle();
    expect_rd("r4_blocked", 4, 32'h33);
    expect_rd("r9_latched", 9, 32'h77);
    expect_rd("r12_untouched", 12, 32'h0);

    // Abort: reset during AGUARDA, then confirm
    bus.pedidoEntrada = 1; bus.enderecoEntrada = 6; cycle(); idle();
    reset = 1; cycle(); idle();
    n_conc = 0;
    bus.confirmaEntrada = 1; bus.dadoSwitch = 32'hBEEF; cycle(); idle();
    cycle();
    check("abort_no_pulse", n_conc, 0);
    check("abort_idle", {31'b0, bus.ocupado}, 32'h0);
    expect_rd("r6_abort", 6, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset                = ($urandom_range(0, 79) == 0);
      bus.escritaHabilita  = $urandom_range(0, 1);
      bus.enderecoEscrita  = 5'($urandom_range(0, 15));
      bus.dadoEscrita      = $urandom;
      bus.pedidoEntrada    = ($urandom_range(0, 5) == 0);
      bus.enderecoEntrada  = 5'($urandom_range(0, 31));
      bus.confirmaEntrada  = ($urandom_range(0, 3) == 0);
      bus.dadoSwitch       = $urandom;
      bus.enderecoLeitura1 = ($urandom_range(0, 2) == 0) ? bus.enderecoEscrita : 5'($urandom_range(0, 15));
      bus.enderecoLeitura2 = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
